axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
AXI3-subset slave that responds to the CPU-side AXI bridge and fronts a single-port synchronous SRAM. It serves the bench and SoC memory model for the cpu_axi_sram_interface initiator. It accepts one transaction at a time, read or write, with single-beat or INCR/FIXED bursts of up to 16 beats. Each transaction is converted into word-wide SRAM accesses with byte enables.

Parameters:
ADDR_W, 16, SRAM word-address width; SRAM holds 2^ADDR_W 32-bit words
BASE, 32'h0000_0000, byte base address of the SRAM window; must be aligned to 2^(ADDR_W+2)

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
arid / araddr / arlen / arsize / arburst  input  4/32/8/3/2  read address channel
arvalid  input  1  read address valid
arready  output  1  read address accept
rid / rdata / rresp / rlast  output  4/32/2/1  read data channel
rvalid  output  1  read data valid
rready  input  1  read data accept
awid / awaddr / awlen / awsize / awburst  input  4/32/8/3/2  write address channel
awvalid  input  1  write address valid
awready  output  1  write address accept
wid / wdata / wstrb / wlast  input  4/32/4/1  write data channel; wid ignored
wvalid  input  1  write data valid
wready  output  1  write data accept
bid / bresp  output  4/2  write response
bvalid  output  1  write response valid
bready  input  1  write response accept
arlock, arcache, arprot, awlock, awcache, awprot  input  2/4/3 each  accepted, ignored
sram_en  output  1  SRAM access strobe
sram_we  output  4  byte write enables; 0 = read
sram_addr  output  ADDR_W  word address
sram_wdata  output  32  write data
sram_rdata  input  32  read data, valid the cycle after sram_en with sram_we == 0

Behaviour:
- Reset (async, resetn low): state IDLE. All of these are 0: arready, awready, wready, rvalid, bvalid, rlast, rresp, bresp, rid, bid, rdata, sram_en, sram_we. The round-robin pointer is 0, which means write wins next. A reset mid-burst abandons the transaction and issues no response.
- FSM states: IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP.
- IDLE: arready = arvalid & !(awvalid & ptr_wr); awready = awvalid & !(arvalid & !ptr_wr).
  - When both arvalid and awvalid are high, ptr selects the winner. ptr toggles after each grant of a contended pair.
  - An AR handshake captures the ID, address, length (len = arlen[3:0]; arlen[7:4] ignored) and burst type, then moves to RD_REQ. An AW handshake does the same for the write side and moves to WR_DATA.
- Beat address: the word address starts at addr[ADDR_W+1:2].
  - INCR (and reserved/WRAP, treated as INCR): +1 per beat, wrapping modulo 2^ADDR_W.
  - FIXED: unchanged.
  - The address is word-aligned; size and the low address bits are ignored, and byte selection is by wstrb only.
- Range check: addr[31:ADDR_W+2] != BASE[31:ADDR_W+2] means the whole transaction is out of range. Every beat then returns DECERR (2'b11), the SRAM is not accessed (sram_en stays 0), and rdata = 0. Otherwise resp is OKAY (2'b00).
- RD_REQ: sram_en = 1, sram_we = 0 for one cycle, then go to RD_RESP.
- RD_RESP: rvalid = 1 and rdata is registered from sram_rdata. rid is the captured ID and rlast = (beat == len). All of these are held stable until rready.
  - On handshake: if last, go to IDLE; otherwise advance the address and go to RD_REQ.
  - Latency: AR handshake in cycle T gives the first rvalid in T+2, and the next beat 2 cycles after each R handshake.
- WR_DATA: wready = 1. On wvalid the write completes in the same cycle: sram_en = 1, sram_we = wstrb, sram_wdata = wdata.
  - The beat counter increments. When beat == len, go to WR_RESP.
  - wlast is checked: wlast must be 1 exactly on beat len. A mismatch on any beat latches SLVERR (2'b10) for bresp, unless DECERR applies, which takes precedence. The beat count still follows awlen.
  - wstrb = 0 still counts as a beat, with sram_we = 0.
- WR_RESP: bvalid = 1 and bid is the captured ID, held until bready; then go to IDLE. Write latency from the last W handshake to bvalid is 1 cycle.
- No address or data is accepted outside the states listed above. A W beat arriving before its AW is held off with wready = 0.

Optional Feature:
AXI_SRAM_SLV_STALL_EN:
- Defined: an 8-bit LFSR (taps 8,6,5,4, seed 8'hA5, reset to seed) advances every cycle. When lfsr[1:0] == 2'b00:
  - arready, awready and wready are forced to 0.
  - A state waiting to raise rvalid or bvalid delays the raise.
  - An already-raised valid stays high.
  - This stresses the initiator's handshakes.
- Undefined: no stalls; timing is exactly as in Behaviour.

Test Plan:
1. Preload word 0x10 = 32'hDEADBEEF. AR with addr 0x40, len 0, id 1, rready = 1 -> arready in T, rvalid in T+2, rdata DEADBEEF, rid 1, rlast 1, rresp 00.
2. Word 0x11 = 32'h11223344. AW at 0x44, then W with wdata 32'hAABBCCDD, wstrb 4'b0011, wlast 1 -> sram_we 0011, word becomes 32'h1122CCDD, bvalid 1 cycle later, bresp 00.
3. INCR read at 0x0, len 3; rready toggles 1,0,1,... -> 4 beats, words 0..3 in order, data held stable while rready = 0, rlast only on beat 4.
4. arvalid and awvalid rise in the same cycle, twice in succession -> write is granted first, then read; on the next contended pair, read first.
5. ADDR_W = 16, read at 32'h0004_0000 (len 1) and write at the same address -> 2 R beats with rresp 11 and rdata 0; bresp 11; sram_en never asserted.
6. resetn pulsed low during beat 2 of a len-3 write -> all valid/ready outputs 0 asynchronously; no bvalid afterwards; the next AR is served normally.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI3-subset bus between the CPU-side bridge (master) and the SRAM slave.
// Carries the AR/R/AW/W/B channels, including the ignored lock/cache/prot fields.
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3-subset slave fronting a single-port synchronous SRAM, one transaction at a time.
// Define AXI_SRAM_SLV_STALL_EN to add LFSR-driven handshake stalls.
module axi_sram_slave #(
  parameter int unsigned ADDR_W = 16,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  axi_sram_slave_if.slave   axi,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state, state_n;
  logic              ptr_rd, live_q;
  logic [3:0]        id_q, len_q, beat_q;
  logic [ADDR_W-1:0] addr_q;
  logic              fixed_q, dec_q, werr_q, rd_first_q, rv_up, bv_up;
  logic [31:0]       rdata_q;
  logic              stall, last_beat, ar_oor, aw_oor;
  logic              arready_c, awready_c, wready_c, rvalid_c, bvalid_c;
  logic              r_go, w_go;

`ifdef AXI_SRAM_SLV_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= 8'hA5;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign last_beat = (beat_q == len_q);
  assign ar_oor    = (axi.araddr[31:ADDR_W+2] != BASE[31:ADDR_W+2]);
  assign aw_oor    = (axi.awaddr[31:ADDR_W+2] != BASE[31:ADDR_W+2]);

  always_comb begin
    state_n   = state;
    arready_c = 1'b0;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    rvalid_c  = 1'b0;
    bvalid_c  = 1'b0;
    sram_en   = 1'b0;
    sram_we   = '0;
    case (state)
      IDLE: begin
        // live_q keeps both address channels closed while reset is asserted
        arready_c = live_q & ~stall & axi.arvalid & ~(axi.awvalid & ~ptr_rd);
        awready_c = live_q & ~stall & axi.awvalid & ~(axi.arvalid & ptr_rd);
        if (arready_c)      state_n = RD_REQ;
        else if (awready_c) state_n = WR_DATA;
      end
      RD_REQ: begin
        sram_en = ~dec_q;
        state_n = RD_RESP;
      end
      RD_RESP: begin
        rvalid_c = rv_up | ~stall;
        if (rvalid_c & axi.rready) state_n = last_beat ? IDLE : RD_REQ;
      end
      WR_DATA: begin
        wready_c = ~stall;
        if (wready_c & axi.wvalid) begin
          sram_en = ~dec_q;
          sram_we = dec_q ? 4'b0000 : axi.wstrb;
          if (last_beat) state_n = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid_c = bv_up | ~stall;
        if (bvalid_c & axi.bready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign r_go = rvalid_c & axi.rready;
  assign w_go = wready_c & axi.wvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      ptr_rd     <= 1'b0;
      live_q     <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      addr_q     <= '0;
      fixed_q    <= 1'b0;
      dec_q      <= 1'b0;
      werr_q     <= 1'b0;
      rd_first_q <= 1'b0;
      rv_up      <= 1'b0;
      bv_up      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state      <= state_n;
      live_q     <= 1'b1;
      rd_first_q <= (state == RD_REQ);
      rv_up      <= rvalid_c & ~axi.rready;
      bv_up      <= bvalid_c & ~axi.bready;
      if (rd_first_q) rdata_q <= sram_rdata;
      if (arready_c) begin
        id_q    <= axi.arid;
        addr_q  <= axi.araddr[ADDR_W+1:2];
        len_q   <= axi.arlen[3:0];
        fixed_q <= (axi.arburst == 2'b00);
        beat_q  <= '0;
        dec_q   <= ar_oor;
        werr_q  <= 1'b0;
        if (axi.awvalid) ptr_rd <= ~ptr_rd;
      end
      if (awready_c) begin
        id_q    <= axi.awid;
        addr_q  <= axi.awaddr[ADDR_W+1:2];
        len_q   <= axi.awlen[3:0];
        fixed_q <= (axi.awburst == 2'b00);
        beat_q  <= '0;
        dec_q   <= aw_oor;
        werr_q  <= 1'b0;
        if (axi.arvalid) ptr_rd <= ~ptr_rd;
      end
      if ((r_go & ~last_beat) | w_go) begin
        beat_q <= beat_q + 4'd1;
        if (!fixed_q) addr_q <= addr_q + ADDR_ONE;
      end
      if (w_go && (axi.wlast != last_beat)) werr_q <= 1'b1;
    end
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = axi.wdata;

  assign axi.arready = arready_c;
  assign axi.awready = awready_c;
  assign axi.wready  = wready_c;
  assign axi.rvalid  = rvalid_c;
  assign axi.rid     = rvalid_c ? id_q : 4'd0;
  assign axi.rresp   = {2{rvalid_c & dec_q}};
  assign axi.rlast   = rvalid_c & last_beat;
  // First response cycle forwards the SRAM output; later cycles hold the captured copy
  assign axi.rdata   = (rvalid_c & ~dec_q) ? (rd_first_q ? sram_rdata : rdata_q) : 32'd0;
  assign axi.bvalid  = bvalid_c;
  assign axi.bid     = bvalid_c ? id_q : 4'd0;
  assign axi.bresp   = !bvalid_c ? 2'b00 : dec_q ? 2'b11 : werr_q ? 2'b10 : 2'b00;

  logic unused_ok;
  assign unused_ok = ^{axi.arlen[7:4], axi.awlen[7:4], axi.arsize, axi.awsize,
                       axi.araddr[1:0], axi.awaddr[1:0], axi.wid,
                       axi.arlock, axi.arcache, axi.arprot,
                       axi.awlock, axi.awcache, axi.awprot};
endmodule
